// File: rtl/pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain
// -----------------------------------------------------------------------------
// Parametrised chain of pipeline registers. It replaces the hand-written
// per-boundary IF/ID, ID/EX style flip-flop modules in the datapath.
//
// Each stage holds a valid bit, a control field and a data field. The hazard
// unit drives a per-stage stall and a per-stage flush:
//   - A stall on stage i freezes stage i and every stage upstream of it.
//   - A flush on stage i clears that stage at the next edge. Flush wins
//     over a freeze.
//   - The first non-frozen stage directly downstream of a frozen stage loads
//     a bubble, so the frozen instruction is not duplicated (load-use bubble).
// A bubble always carries an all-zero control field. Downstream logic can
// therefore never act on a squashed or empty slot, whatever its valid bit
// reads.
//
// Two saturating 16-bit counters support CPI measurement:
//   - stall_cnt  : edges on which any stall bit was set.
//   - bubble_cnt : edges on which the last stage held no valid instruction.
//
// Parameters
//   WIDTH   data field width (PC+4, operands, immediate, packed by the user)
//   CTRL_W  control field width (zeroed in every bubble)
//   STAGES  number of register stages, legal range 1..8
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-low
//   in_valid     input slot holds a real instruction
//   in_ctrl      control bits entering stage 0
//   in_data      data bits entering stage 0
//   in_ready     stage 0 loads this cycle (combinational, = ~hold[0])
//   stall        per-stage stall, bit i freezes stage i and all upstream
//   flush        per-stage flush, bit i clears stage i at the next edge
//   out_valid    valid bit of the last stage (registered)
//   out_ctrl     control field of the last stage (registered)
//   out_data     data field of the last stage (registered)
//   stage_valid  valid bits of all stages, bit 0 = first stage (registered)
//   stall_cnt    saturating count of stalled edges (registered)
//   bubble_cnt   saturating count of edges with out_valid = 0 (registered)
// -----------------------------------------------------------------------------
module pipe_reg_chain #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 10,
   parameter int STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [WIDTH-1:0]  in_data,
   output logic              in_ready,
   input  logic [STAGES-1:0] stall,
   input  logic [STAGES-1:0] flush,
   output logic              out_valid,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [WIDTH-1:0]  out_data,
   output logic [STAGES-1:0] stage_valid,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       bubble_cnt
);

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   // Saturating increment shared by both performance counters.
   function automatic logic [15:0] sat_inc(input logic [15:0] value,
                                           input logic        enable);
      logic [15:0] result;
      if (enable && (value != CNT_MAX)) begin
         result = value + 16'd1;
      end else begin
         result = value;
      end
      return result;
   endfunction

   // ---------------------------------------------------------------------
   // Stage storage and next-state
   // ---------------------------------------------------------------------
   logic [STAGES-1:0]             valid_r;
   logic [STAGES-1:0][CTRL_W-1:0] ctrl_r;
   logic [STAGES-1:0][WIDTH-1:0]  data_r;

   logic [STAGES-1:0]             valid_nx_s;
   logic [STAGES-1:0][CTRL_W-1:0] ctrl_nx_s;
   logic [STAGES-1:0][WIDTH-1:0]  data_nx_s;

   // hold_s[i] is set when stage i or any stage downstream of it is stalled.
   logic [STAGES-1:0]             hold_s;

   logic [15:0] stall_cnt_r;
   logic [15:0] bubble_cnt_r;
   logic [15:0] stall_cnt_nx_s;
   logic [15:0] bubble_cnt_nx_s;

   // Hold propagation: sweep from the last stage back toward stage 0. An
   // accumulator is used so the vector never depends on itself.
   always_comb begin
      logic hold_acc_s;
      hold_acc_s = 1'b0;
      hold_s     = {STAGES{1'b0}};
      for (int i = STAGES - 1; i >= 0; i--) begin
         hold_acc_s = hold_acc_s | stall[i];
         hold_s[i]  = hold_acc_s;
      end
   end

   // Stage 0 loads exactly when nothing anywhere in the chain is stalled.
   assign in_ready = ~hold_s[0];

   genvar g;
   for (g = 0; g < STAGES; g++) begin : g_stage
      logic              src_valid_s;
      logic [CTRL_W-1:0] src_ctrl_s;
      logic [WIDTH-1:0]  src_data_s;
      logic              up_hold_s;
      logic              stg_valid_nx_s;
      logic [CTRL_W-1:0] stg_ctrl_nx_s;
      logic [WIDTH-1:0]  stg_data_nx_s;

      if (g == 0) begin : g_head
         // The input slot is the source. An invalid input never carries
         // live control bits. Data is captured unconditionally.
         assign src_valid_s = in_valid;
         assign src_ctrl_s  = in_valid ? in_ctrl : {CTRL_W{1'b0}};
         assign src_data_s  = in_data;
         // Stage 0 has no upstream register, so it never loads a bubble.
         assign up_hold_s   = 1'b0;
      end else begin : g_body
         assign src_valid_s = valid_r[g-1];
         assign src_ctrl_s  = ctrl_r[g-1];
         assign src_data_s  = data_r[g-1];
         assign up_hold_s   = hold_s[g-1];
      end

      // Per-stage priority: flush, then hold, then bubble behind a frozen
      // upstream stage, then a normal load from the upstream source.
      always_comb begin
         stg_valid_nx_s = valid_r[g];
         stg_ctrl_nx_s  = ctrl_r[g];
         stg_data_nx_s  = data_r[g];
         if (flush[g]) begin
            stg_valid_nx_s = 1'b0;
            stg_ctrl_nx_s  = {CTRL_W{1'b0}};
            stg_data_nx_s  = {WIDTH{1'b0}};
         end else if (hold_s[g]) begin
            stg_valid_nx_s = valid_r[g];
            stg_ctrl_nx_s  = ctrl_r[g];
            stg_data_nx_s  = data_r[g];
         end else if (up_hold_s) begin
            stg_valid_nx_s = 1'b0;
            stg_ctrl_nx_s  = {CTRL_W{1'b0}};
            stg_data_nx_s  = {WIDTH{1'b0}};
         end else begin
            stg_valid_nx_s = src_valid_s;
            stg_ctrl_nx_s  = src_ctrl_s;
            stg_data_nx_s  = src_data_s;
         end
      end

      assign valid_nx_s[g] = stg_valid_nx_s;
      assign ctrl_nx_s[g]  = stg_ctrl_nx_s;
      assign data_nx_s[g]  = stg_data_nx_s;
   end

   // Counter next-state. The bubble count samples the last stage as it
   // stands before the edge, which is what out_valid currently shows.
   always_comb begin
      stall_cnt_nx_s  = sat_inc(stall_cnt_r, |stall);
      bubble_cnt_nx_s = sat_inc(bubble_cnt_r, ~valid_r[STAGES-1]);
   end

   // Stage registers and counters. Reset clears everything and overrides
   // stall and flush.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_r      <= {STAGES{1'b0}};
         ctrl_r       <= {(STAGES*CTRL_W){1'b0}};
         data_r       <= {(STAGES*WIDTH){1'b0}};
         stall_cnt_r  <= 16'h0000;
         bubble_cnt_r <= 16'h0000;
      end else begin
         valid_r      <= valid_nx_s;
         ctrl_r       <= ctrl_nx_s;
         data_r       <= data_nx_s;
         stall_cnt_r  <= stall_cnt_nx_s;
         bubble_cnt_r <= bubble_cnt_nx_s;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: straight from registers, so stall and flush never reach
   // out_* combinationally.
   // ---------------------------------------------------------------------
   assign out_valid   = valid_r[STAGES-1];
   assign out_ctrl    = ctrl_r[STAGES-1];
   assign out_data    = data_r[STAGES-1];
   assign stage_valid = valid_r;
   assign stall_cnt   = stall_cnt_r;
   assign bubble_cnt  = bubble_cnt_r;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg_chain
// Directed scenarios followed by randomized traffic. Expected values come from
// a reference model that tracks the instruction slots as an array of records.
// -----------------------------------------------------------------------------
module tb_pipe_reg_chain;

   localparam int STG = 2;
   localparam int CW  = 10;
   localparam int W   = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic [CW-1:0]  in_ctrl;
   logic [W-1:0]   in_data;
   logic           in_ready;
   logic [STG-1:0] stall;
   logic [STG-1:0] flush;
   logic           out_valid;
   logic [CW-1:0]  out_ctrl;
   logic [W-1:0]   out_data;
   logic [STG-1:0] stage_valid;
   logic [15:0]    stall_cnt;
   logic [15:0]    bubble_cnt;

   pipe_reg_chain #(.WIDTH(W), .CTRL_W(CW), .STAGES(STG)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
      .in_data(in_data), .in_ready(in_ready), .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_ctrl(out_ctrl), .out_data(out_data),
      .stage_valid(stage_valid), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: one record per slot plus plain integer counters.
   typedef struct {
      bit            v;
      logic [CW-1:0] c;
      logic [W-1:0]  d;
   } slot_t;

   slot_t m[STG];
   int    m_stall;
   int    m_bub;
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply the edge's effect to the model using the currently driven inputs.
   task automatic model_edge();
      slot_t nx[STG];
      bit    frz[STG];
      if (!rst) begin
         for (int i = 0; i < STG; i++) begin
            nx[i].v = 1'b0; nx[i].c = '0; nx[i].d = '0;
         end
         m_stall = 0;
         m_bub   = 0;
      end else begin
         if (stall != '0 && m_stall < 65535) m_stall++;
         if (!m[STG-1].v && m_bub < 65535) m_bub++;
         // A slot is frozen if any stall bit at or after its position is set.
         for (int i = 0; i < STG; i++) frz[i] = ((stall >> i) != '0);
         for (int i = 0; i < STG; i++) begin
            if (flush[i] || (!frz[i] && i > 0 && frz[i-1])) begin
               nx[i].v = 1'b0; nx[i].c = '0; nx[i].d = '0;
            end else if (frz[i]) begin
               nx[i] = m[i];
            end else if (i == 0) begin
               nx[i].v = in_valid;
               nx[i].c = in_valid ? in_ctrl : '0;
               nx[i].d = in_data;
            end else begin
               nx[i] = m[i-1];
            end
         end
      end
      for (int i = 0; i < STG; i++) m[i] = nx[i];
   endtask

   task automatic check_all();
      logic [STG-1:0] sv;
      for (int i = 0; i < STG; i++) sv[i] = m[i].v;
      chk("out_valid", out_valid, m[STG-1].v);
      chk("out_ctrl", out_ctrl, m[STG-1].c);
      chk("out_data", out_data, m[STG-1].d);
      chk("stage_valid", stage_valid, sv);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("bubble_cnt", bubble_cnt, m_bub);
   endtask

   // One clock cycle: drive, check in_ready, take the edge, check outputs.
   task automatic cyc(input logic r, input logic v, input logic [CW-1:0] c,
                      input logic [W-1:0] d, input logic [STG-1:0] st,
                      input logic [STG-1:0] fl, input bit do_chk);
      rst = r; in_valid = v; in_ctrl = c; in_data = d; stall = st; flush = fl;
      #1;
      if (do_chk) chk("in_ready", in_ready, st == '0);
      @(posedge clk);
      model_edge();
      #1;
      if (do_chk) check_all();
   endtask

   initial begin
      int base;
      for (int i = 0; i < STG; i++) begin
         m[i].v = 1'b0; m[i].c = '0; m[i].d = '0;
      end
      m_stall = 0;
      m_bub   = 0;

      // 1. Reset for two edges with a valid, patterned input.
      cyc(1'b0, 1'b1, 10'h155, 32'hAAAA_AAAA, 2'b00, 2'b00, 1'b1);
      cyc(1'b0, 1'b1, 10'h155, 32'hAAAA_AAAA, 2'b00, 2'b00, 1'b1);
      chk("rst_stage_valid", stage_valid, 2'b00);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_stall_cnt", stall_cnt, 16'h0);

      // 2. Streaming: two-edge latency, one per cycle.
      cyc(1'b1, 1'b1, 10'h101, 32'h11, 2'b00, 2'b00, 1'b1);
      cyc(1'b1, 1'b1, 10'h102, 32'h22, 2'b00, 2'b00, 1'b1);
      chk("stream_first", out_data, 32'h11);
      cyc(1'b1, 1'b1, 10'h103, 32'h33, 2'b00, 2'b00, 1'b1);
      chk("stream_second", out_data, 32'h22);
      cyc(1'b1, 1'b0, 10'h000, 32'h0, 2'b00, 2'b00, 1'b1);
      chk("stream_third", out_data, 32'h33);
      chk("stream_valid", out_valid, 1'b1);

      // 3. Load-use bubble: A in stage 0, B held at input under stall=01.
      cyc(1'b1, 1'b1, 10'h0A1, 32'h11, 2'b00, 2'b00, 1'b1);
      base = m_stall;
      cyc(1'b1, 1'b1, 10'h0B2, 32'h22, 2'b01, 2'b00, 1'b1);
      chk("lu_bubble_valid", out_valid, 1'b0);
      chk("lu_bubble_ctrl", out_ctrl, 10'h0);
      chk("lu_stall_cnt", stall_cnt, 16'(base + 1));
      cyc(1'b1, 1'b1, 10'h0B2, 32'h22, 2'b00, 2'b00, 1'b1);
      chk("lu_out_a", out_data, 32'h11);
      cyc(1'b1, 1'b0, 10'h000, 32'h0, 2'b00, 2'b00, 1'b1);
      chk("lu_out_b", out_data, 32'h22);

      // 4. Downstream stall freezes both stages for three edges.
      cyc(1'b1, 1'b1, 10'h044, 32'h44, 2'b00, 2'b00, 1'b1);
      cyc(1'b1, 1'b1, 10'h055, 32'h55, 2'b00, 2'b00, 1'b1);
      base = m_stall;
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 1'b1, 10'h066, 32'h66, 2'b10, 2'b00, 1'b1);
         chk("ds_frozen_out", out_data, 32'h44);
         chk("ds_frozen_sv", stage_valid, 2'b11);
      end
      chk("ds_stall_cnt", stall_cnt, 16'(base + 3));

      // 5. Flush beats hold on stage 0; stage 1 takes a bubble.
      cyc(1'b1, 1'b1, 10'h066, 32'h66, 2'b00, 2'b00, 1'b1);
      cyc(1'b1, 1'b1, 10'h077, 32'h77, 2'b01, 2'b01, 1'b1);
      chk("fl_stage_valid", stage_valid, 2'b00);
      chk("fl_out_ctrl", out_ctrl, 10'h0);

      // 6. Saturation under a long downstream stall, then mid-op reset.
      for (int k = 0; k < 65540; k++) begin
         cyc(1'b1, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 2'b10, 2'b00, 1'b0);
      end
      check_all();
      chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
      cyc(1'b1, 1'b1, 10'h3FF, 32'hCAFE_0001, 2'b00, 2'b00, 1'b1);
      chk("sat_hold", stall_cnt, 16'hFFFF);
      cyc(1'b0, 1'b1, 10'h3FF, 32'hCAFE_0002, 2'b11, 2'b11, 1'b1);
      chk("mid_rst_sv", stage_valid, 2'b00);
      chk("mid_rst_stall", stall_cnt, 16'h0);
      chk("mid_rst_bubble", bubble_cnt, 16'h0);

      // Randomized traffic with occasional stalls, flushes and resets.
      for (int k = 0; k < 400; k++) begin
         logic           r;
         logic [STG-1:0] st;
         logic [STG-1:0] fl;
         r  = ($urandom_range(0, 49) != 0);
         st = ($urandom_range(0, 2) == 0) ? STG'($urandom_range(1, 3)) : '0;
         fl = ($urandom_range(0, 5) == 0) ? STG'($urandom_range(1, 3)) : '0;
         cyc(r, 1'($urandom_range(0, 1)), CW'($urandom()), $urandom(), st, fl, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
Parametrised successor to the fixed IF/ID and ID/EX pipeline registers. It is a chain of STAGES pipeline registers, each carrying a control field and a data field plus a valid bit. Per-stage stall (hold) and flush inputs let the hazard unit insert bubbles and squash wrong-path instructions. Saturating stall and bubble counters support CPI measurement. It replaces hand-written per-boundary flip-flop modules in the datapath.

Parameters:
WIDTH, 32, data field width (PC+4, register operands, sign-extended immediate, concatenated by the instantiator).
CTRL_W, 10, control field width (wr_en, regdst, memwrite, etc.). This field is forced to zero in bubbles.
STAGES, 2, number of register stages; legal range 1..8.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-low (0 = reset on next rising edge).
in_valid  input  1  input slot holds a real instruction.
in_ctrl  input  CTRL_W  control bits entering stage 0.
in_data  input  WIDTH  data bits entering stage 0.
in_ready  output  1  stage 0 will load this cycle; equals ~hold[0]. Combinational.
stall  input  STAGES  stall[i]=1 freezes stage i and every stage upstream of it.
flush  input  STAGES  flush[i]=1 clears stage i at the next edge.
out_valid  output  1  valid bit of the last stage.
out_ctrl  output  CTRL_W  control field of the last stage.
out_data  output  WIDTH  data field of the last stage.
stage_valid  output  STAGES  valid bit of every stage; bit 0 is the first stage.
stall_cnt  output  16  count of cycles with any stall bit set; saturating.
bubble_cnt  output  16  count of cycles with out_valid=0; saturating.

Behaviour:
- Reset (rst=0 at an edge): all stage valid, ctrl and data bits go to 0; stall_cnt and bubble_cnt go to 0. Reset overrides stall and flush. No residue survives a mid-operation reset.
- hold[i] = OR of stall[i..STAGES-1]. A downstream stall freezes all upstream stages.
- Per-stage update at each edge while rst=1, in priority order:
  1. flush[i]=1: valid=0, ctrl=0, data=0. Flush beats hold.
  2. Else if hold[i]=1: the stage keeps its contents.
  3. Else if i>0 and hold[i-1]=1: the stage loads a bubble (valid=0, ctrl=0, data=0). This is load-use bubble insertion.
  4. Else: the stage loads its upstream source. The source is stage i-1, or for stage 0 the inputs {in_valid, in_ctrl, in_data}.
- Stage 0 with in_valid=0 loads valid=0 and ctrl=0. Data is still captured from in_data.
- Latency with no stall or flush: exactly STAGES cycles from input to out_*. Throughput is one instruction per cycle.
- Handshake: when in_ready=0 the source must hold its inputs stable. The inputs are ignored that cycle.
- Counter rules, evaluated with rst=1:
  - stall_cnt increments on any edge where |stall=1.
  - bubble_cnt increments on any edge where the current out_valid=0.
  - Both saturate at 0xFFFF with no wrap.
- No combinational path from stall or flush to out_*. The only combinational output is in_ready.
- STAGES=1: the hold[i-1] bubble rule does not apply.
- Outputs are registers only.

Test Plan:
1. Reset: STAGES=2, in_valid=1, in_data=0xAAAA_AAAA, rst=0 for 2 edges -> stage_valid=00, out_ctrl=0, out_data=0, both counters 0, in_ready=1.
2. Streaming: in_data 0x11, 0x22, 0x33 with in_valid=1 on consecutive cycles, no stall -> out_data=0x11 two edges after first presentation, then 0x22 and 0x33 on the following edges, out_valid=1 throughout.
3. Load-use bubble: A (0x11) in stage0, B (0x22) at input, stall=01 for one edge -> in_ready=0 that cycle. Stage0 keeps A and stage1 gets a bubble (ctrl=0). The output sequence is bubble, A, B. bubble_cnt increments once for the bubble, stall_cnt=1.
4. Downstream stall: stall=10 for 3 edges with valid data in both stages -> both stages frozen, out_data constant, no bubble inserted, stall_cnt=3, in_ready=0.
5. Flush priority: stall=01 and flush=01 on the same edge with valid data in stage0 -> stage0 cleared (valid=0, ctrl=0), stage1 gets a bubble, stage_valid=00 after the edge.
6. Saturation and mid-op reset: hold stall=10 for 65540 cycles -> stall_cnt stays at 0xFFFF. Then rst=0 for one edge -> counters=0 and stage_valid=00 regardless of stall and flush.
